// File: rtl/brick_field_engine.sv
// Brick-smasher game core: brick array, once-per-frame ball motion, pixel-overlap
// collision capture, serve/lives/refill FSM and registered graphics layers.
module brick_field_engine #(
    parameter int BRICKS_H     = 16,
    parameter int BRICKS_V     = 8,
    parameter int BRICK_Y0     = 64,
    parameter int PADDLE_Y     = 224,
    parameter int PADDLE_WIDTH = 31,
    parameter int BALL_SIZE    = 6,
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int SERVE_X      = 128,
    parameter int SERVE_Y      = 180,
    parameter int MISS_Y       = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       frame_tick,
    input  logic [8:0] paddle_x,
    output logic       brick_gfx,
    output logic       ball_gfx,
    output logic       paddle_gfx,
    output logic       incscore,
    output logic       declives,
    output logic [3:0] lives,
    output logic [8:0] bricks_left,
    output logic       game_over
);
    localparam int NB    = BRICKS_H * BRICKS_V;
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0] AX1     = 10'(16 + 16 * BRICKS_H);
    localparam logic [9:0] AY0     = 10'(BRICK_Y0);
    localparam logic [9:0] AY1     = 10'(BRICK_Y0 + 8 * BRICKS_V);
    localparam logic [9:0] PY0     = 10'(PADDLE_Y);
    localparam logic [9:0] PY1     = 10'(PADDLE_Y + 8);
    localparam logic [8:0] PW      = 9'(PADDLE_WIDTH);
    localparam logic [8:0] BS      = 9'(BALL_SIZE);
    localparam logic [8:0] HALF_BS = 9'(BALL_SIZE / 2);
    localparam logic [8:0] Q1      = 9'(PADDLE_WIDTH / 4);
    localparam logic [8:0] Q3      = 9'(3 * PADDLE_WIDTH / 4);
    localparam logic [8:0] PMAX    = 9'(511 - PADDLE_WIDTH);
    localparam logic [8:0] SX      = 9'(SERVE_X);
    localparam logic [8:0] SY      = 9'(SERVE_Y);
    localparam logic [8:0] MY      = 9'(MISS_Y);
    localparam logic [8:0] NB9     = 9'(NB);
    localparam logic [3:0] LIVES0  = 4'(LIVES_INIT);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_CLEARED, S_OVER} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [8:0]       ball_x, ball_x_n, ball_y, ball_y_n, paddle_pos, paddle_pos_n;
    logic             dir_right, dir_right_n, dir_up, dir_up_n, speed_x, speed_x_n;
    logic [NB-1:0]    bricks, bricks_n;
    logic [8:0]       bricks_left_n, step;
    logic [3:0]       lives_n;
    logic             inc_n, dec_n;

    logic [8:0] hx, vy, bdx, bdy, pdx, scan_idx;
    logic       in_area, brick_here, brick_px, border_px, ball_px, paddle_px;

    always_comb begin
        hx        = hpos - 9'd16;
        vy        = vpos - AY0[8:0];
        bdx       = hpos - ball_x;
        bdy       = vpos - ball_y;
        pdx       = hpos - paddle_pos;
        in_area   = ({1'b0, hpos} >= 10'd16) && ({1'b0, hpos} < AX1) &&
                    ({1'b0, vpos} >= AY0) && ({1'b0, vpos} < AY1);
        scan_idx  = 9'(vy[8:3] * BRICKS_H) + 9'(hx[8:4]);
        brick_here = 1'b0;
        for (int i = 0; i < NB; i++)
            if (scan_idx == 9'(i)) brick_here = bricks[i];
        // BRICK_Y0 is a multiple of 8, so vy[2:0] is the mortar row test on vpos
        brick_px  = in_area && brick_here && (hx[3:0] != 4'd0) && (vy[2:0] != 3'd0);
        border_px = (hpos[8:3] == 6'd0) || (hpos[8:3] == 6'd31);
        ball_px   = (bdx < BS) && (bdy < BS);
        paddle_px = ({1'b0, vpos} >= PY0) && ({1'b0, vpos} < PY1) && (pdx < PW);
    end

    // ---- stage p1: registered graphics layers ----
    logic       brick_only_p1, border_p1;
    logic [8:0] idx_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brick_gfx     <= 1'b0;
            ball_gfx      <= 1'b0;
            paddle_gfx    <= 1'b0;
            brick_only_p1 <= 1'b0;
            border_p1     <= 1'b0;
        end else begin
            brick_gfx     <= display_on && (brick_px || border_px);
            ball_gfx      <= display_on && ball_px;
            paddle_gfx    <= display_on && paddle_px;
            brick_only_p1 <= display_on && brick_px && !border_px;
            border_p1     <= display_on && border_px;
        end
    end

    always_ff @(posedge clk) idx_p1 <= scan_idx;

    // ---- stage p2: collision capture from overlapping layers ----
    logic       brick_hit, paddle_hit, side_hit;
    logic [8:0] hit_idx, paddle_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brick_hit  <= 1'b0;
            paddle_hit <= 1'b0;
            side_hit   <= 1'b0;
        end else if (frame_tick) begin
            brick_hit  <= 1'b0;
            paddle_hit <= 1'b0;
            side_hit   <= 1'b0;
        end else begin
            if (ball_gfx && brick_only_p1) brick_hit <= 1'b1;
            if (ball_gfx && paddle_gfx)    paddle_hit <= 1'b1;
            if (ball_gfx && border_p1)     side_hit <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!frame_tick && ball_gfx && brick_only_p1 && !brick_hit) hit_idx <= idx_p1;
        if (!frame_tick && ball_gfx && paddle_gfx) paddle_off <= ball_x + HALF_BS - paddle_pos;
    end

    // ---- game FSM, advanced once per frame ----
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        ball_x_n      = ball_x;
        ball_y_n      = ball_y;
        dir_right_n   = dir_right;
        dir_up_n      = dir_up;
        speed_x_n     = speed_x;
        bricks_n      = bricks;
        bricks_left_n = bricks_left;
        lives_n       = lives;
        paddle_pos_n  = paddle_pos;
        inc_n         = 1'b0;
        dec_n         = 1'b0;
        step          = 9'd1;
        if (frame_tick) begin
            paddle_pos_n = (paddle_x > PMAX) ? PMAX : paddle_x;
            case (state)
                S_SERVE: begin
                    ball_x_n = SX;
                    ball_y_n = SY;
                    dir_up_n = 1'b1;
                    if (cnt == SERVE_LAST) begin
                        state_n = S_PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (ball_y >= MY) begin
                        dec_n   = 1'b1;
                        lives_n = lives - 4'd1;
                        if (lives == 4'd1) begin
                            state_n = S_OVER;
                        end else begin
                            state_n  = S_SERVE;
                            ball_x_n = SX;
                            ball_y_n = SY;
                            dir_up_n = 1'b1;
                        end
                    end else begin
                        if (brick_hit) begin
                            for (int i = 0; i < NB; i++)
                                if (hit_idx == 9'(i)) bricks_n[i] = 1'b0;
                            bricks_left_n = bricks_left - 9'd1;
                            inc_n         = 1'b1;
                            dir_up_n      = !dir_up;
                        end
                        if (paddle_hit) begin
                            dir_up_n  = 1'b1;
                            speed_x_n = (paddle_off < Q1) || (paddle_off >= Q3);
                        end
                        if (side_hit) dir_right_n = !dir_right;
                        if ((ball_y <= 9'd8) && dir_up_n) dir_up_n = 1'b0;
                        step = {8'd0, speed_x_n} + 9'd1;
                        if (brick_hit && (bricks_left == 9'd1)) begin
                            state_n = S_CLEARED;
                        end else begin
                            ball_x_n = dir_right_n ? ball_x + step : ball_x - step;
                            ball_y_n = dir_up_n ? ball_y - 9'd1 : ball_y + 9'd1;
                        end
                    end
                end
                S_CLEARED: begin
                    bricks_n      = '1;
                    bricks_left_n = NB9;
                    state_n       = S_SERVE;
                    cnt_n         = '0;
                    ball_x_n      = SX;
                    ball_y_n      = SY;
                    dir_up_n      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_SERVE;
            cnt         <= '0;
            ball_x      <= SX;
            ball_y      <= SY;
            dir_right   <= 1'b1;
            dir_up      <= 1'b1;
            speed_x     <= 1'b0;
            bricks      <= '1;
            bricks_left <= NB9;
            lives       <= LIVES0;
            paddle_pos  <= 9'd0;
            incscore    <= 1'b0;
            declives    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ball_x      <= ball_x_n;
            ball_y      <= ball_y_n;
            dir_right   <= dir_right_n;
            dir_up      <= dir_up_n;
            speed_x     <= speed_x_n;
            bricks      <= bricks_n;
            bricks_left <= bricks_left_n;
            lives       <= lives_n;
            paddle_pos  <= paddle_pos_n;
            incscore    <= inc_n;
            declives    <= dec_n;
        end
    end

    assign game_over = (state == S_OVER);
endmodule

// File: tb/tb_brick_field_engine.sv
// Directed bench for brick_field_engine: a default-size core and a 2x1 brick core
// sharing the beam/tick inputs, each held in reset while the other is exercised.
module tb_brick_field_engine;
    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [8:0] hpos, vpos, paddle_x;
    logic       display_on, frame_tick;

    logic       brick_gfx_a, ball_gfx_a, paddle_gfx_a, incscore_a, declives_a, game_over_a;
    logic [3:0] lives_a;
    logic [8:0] bricks_left_a;
    logic       brick_gfx_b, ball_gfx_b, paddle_gfx_b, incscore_b, declives_b, game_over_b;
    logic [3:0] lives_b;
    logic [8:0] bricks_left_b;

    brick_field_engine dut_a (
        .clk(clk), .reset(rst_a), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .frame_tick(frame_tick), .paddle_x(paddle_x), .brick_gfx(brick_gfx_a),
        .ball_gfx(ball_gfx_a), .paddle_gfx(paddle_gfx_a), .incscore(incscore_a),
        .declives(declives_a), .lives(lives_a), .bricks_left(bricks_left_a),
        .game_over(game_over_a)
    );

    brick_field_engine #(
        .BRICKS_H(2), .BRICKS_V(1), .BRICK_Y0(64), .PADDLE_Y(64), .PADDLE_WIDTH(31),
        .BALL_SIZE(6), .LIVES_INIT(3), .SERVE_FRAMES(1), .SERVE_X(20), .SERVE_Y(70),
        .MISS_Y(240)
    ) dut_b (
        .clk(clk), .reset(rst_b), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .frame_tick(frame_tick), .paddle_x(paddle_x), .brick_gfx(brick_gfx_b),
        .ball_gfx(ball_gfx_b), .paddle_gfx(paddle_gfx_b), .incscore(incscore_b),
        .declives(declives_b), .lives(lives_b), .bricks_left(bricks_left_b),
        .game_over(game_over_b)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    logic use_b = 1'b0;
    logic g_ball, g_brick, g_paddle, inc_s, dec_s;
    int   n_ticks;
    logic found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        inc_s = use_b ? incscore_b : incscore_a;
        dec_s = use_b ? declives_b : declives_a;
    endtask

    task automatic probe(input logic [8:0] x, input logic [8:0] y, input logic de);
        @(negedge clk);
        hpos = x; vpos = y; display_on = de;
        @(negedge clk);
        g_ball   = use_b ? ball_gfx_b : ball_gfx_a;
        g_brick  = use_b ? brick_gfx_b : brick_gfx_a;
        g_paddle = use_b ? paddle_gfx_b : paddle_gfx_a;
        display_on = 1'b0;
    endtask

    task automatic ball_at(input string tag, input logic [8:0] x, input logic [8:0] y);
        probe(x, y, 1'b1);
        check({tag, "_on"}, 32'(g_ball), 1);
        probe(x - 9'd1, y, 1'b1);
        check({tag, "_left"}, 32'(g_ball), 0);
        probe(x, y - 9'd1, 1'b1);
        check({tag, "_above"}, 32'(g_ball), 0);
    endtask

    task automatic wait_miss(input int bound);
        found = 1'b0;
        n_ticks = 0;
        for (int k = 1; k <= bound && !found; k++) begin
            tick();
            if (dec_s) begin
                found = 1'b1;
                n_ticks = k;
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        hpos = '0; vpos = '0; display_on = 1'b0; frame_tick = 1'b0; paddle_x = 9'd100;
        repeat (3) @(negedge clk);
        check("rst_lives", 32'(lives_a), 3);
        check("rst_bricks", 32'(bricks_left_a), 128);
        check("rst_over", 32'(game_over_a), 0);
        check("rst_outs", 32'({brick_gfx_a, ball_gfx_a, paddle_gfx_a, incscore_a, declives_a}), 0);
        check("rst_bricks_b", 32'(bricks_left_b), 2);
        rst_a = 1'b0;

        probe(9'd17, 9'd65, 1'b1);  check("brick0_px", 32'(g_brick), 1);
        probe(9'd32, 9'd65, 1'b1);  check("mortar_px", 32'(g_brick), 0);
        probe(9'd3, 9'd100, 1'b1);  check("border_px", 32'(g_brick), 1);
        probe(9'd3, 9'd100, 1'b0);  check("blank_px", 32'(g_brick), 0);

        repeat (59) tick();
        ball_at("serve_hold", 9'd128, 9'd180);
        probe(9'd110, 9'd228, 1'b1); check("paddle_in", 32'(g_paddle), 1);
        probe(9'd131, 9'd228, 1'b1); check("paddle_end", 32'(g_paddle), 0);
        tick();
        ball_at("play_entry", 9'd128, 9'd180);
        tick();
        ball_at("first_move", 9'd129, 9'd179);

        repeat (52) tick();
        probe(9'd183, 9'd127, 1'b1);
        check("hit_ball", 32'(g_ball), 1);
        check("hit_brick", 32'(g_brick), 1);
        tick();
        check("incscore", 32'(inc_s), 1);
        @(negedge clk);
        check("incscore_once", 32'(incscore_a), 0);
        check("bricks_127", 32'(bricks_left_a), 127);
        probe(9'd183, 9'd125, 1'b1); check("brick122_gone", 32'(g_brick), 0);
        probe(9'd170, 9'd125, 1'b1); check("brick121_kept", 32'(g_brick), 1);
        tick();
        ball_at("dir_down", 9'd183, 9'd129);

        wait_miss(200);
        check("miss1_ticks", 32'(n_ticks), 112);
        check("lives_2", 32'(lives_a), 2);
        @(negedge clk);
        check("declives_once", 32'(declives_a), 0);
        ball_at("reserve", 9'd128, 9'd180);

        wait_miss(600);
        check("miss2_ticks", 32'(n_ticks), 465);
        check("lives_1", 32'(lives_a), 1);
        wait_miss(600);
        check("miss3_ticks", 32'(n_ticks), 465);
        check("lives_0", 32'(lives_a), 0);
        check("game_over", 32'(game_over_a), 1);
        ball_at("frozen0", 9'd20, 9'd240);
        repeat (100) tick();
        ball_at("frozen100", 9'd20, 9'd240);
        check("over_held", 32'(game_over_a), 1);
        check("lives_held", 32'(lives_a), 0);

        @(negedge clk) #2 rst_a = 1'b1;
        #1;
        check("arst_lives", 32'(lives_a), 3);
        check("arst_over", 32'(game_over_a), 0);
        @(negedge clk) rst_a = 1'b0;
        repeat (61) tick();
        @(negedge clk);
        hpos = 9'd3; vpos = 9'd100; display_on = 1'b1;
        @(negedge clk);
        check("scan_border", 32'(brick_gfx_a), 1);
        #2 rst_a = 1'b1;
        #1;
        check("arst_gfx", 32'(brick_gfx_a), 0);
        check("arst_bricks", 32'(bricks_left_a), 128);
        @(negedge clk) rst_a = 1'b0; display_on = 1'b0;
        repeat (2) @(negedge clk);
        check("gfx_blank", 32'(brick_gfx_a), 0);
        ball_at("arst_ball", 9'd128, 9'd180);

        rst_a = 1'b1; rst_b = 1'b0; use_b = 1'b1;
        paddle_x = 9'd21;
        tick();
        probe(9'd21, 9'd70, 1'b1);
        check("b_triple", 32'({g_ball, g_brick, g_paddle}), 32'h7);
        tick();
        check("b_inc", 32'(inc_s), 1);
        check("b_left1", 32'(bricks_left_b), 1);
        probe(9'd18, 9'd66, 1'b1); check("b_brick0_gone", 32'(g_brick), 0);
        ball_at("b_step2", 9'd22, 9'd69);
        paddle_x = 9'd12;
        tick();
        ball_at("b_off4", 9'd24, 9'd68);
        tick();
        ball_at("b_off15", 9'd25, 9'd67);
        paddle_x = 9'd200;
        repeat (3) tick();
        probe(9'd33, 9'd65, 1'b1);
        check("b_hit1", 32'({g_ball, g_brick}), 32'h3);
        tick();
        check("b_inc_last", 32'(inc_s), 1);
        check("b_left0", 32'(bricks_left_b), 0);
        tick();
        check("b_refill", 32'(bricks_left_b), 2);
        check("b_lives", 32'(lives_b), 3);
        check("b_not_over", 32'(game_over_b), 0);
        probe(9'd17, 9'd65, 1'b1); check("b_brick0_back", 32'(g_brick), 1);
        probe(9'd33, 9'd65, 1'b1); check("b_brick1_back", 32'(g_brick), 1);
        paddle_x = 9'd500;
        tick();
        probe(9'd490, 9'd68, 1'b1); check("b_clamp_in", 32'(g_paddle), 1);
        probe(9'd479, 9'd68, 1'b1); check("b_clamp_edge", 32'(g_paddle), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
